alu_sequencer: RTL
==================

# alu_sequencer

Multi-cycle controller in front of the combinational 32-bit ALU (5-bit OP; A, B; result; O/S/C/Z flags). It accepts one operation at a time over a valid/ready request port and drives the ALU operand and opcode inputs from registers. Multi-bit shifts are built by iterating the ALU's 1-bit `lsl`/`asr` opcodes. The result and sanitised flags are captured and returned over a valid/ready response port. It sits between the instruction decode/execute control and the ALU instance.

## Interface

Parameters:
- `CNT_W`, default 5: width of the shift repeat count.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted this cycle when `req_valid` is also high.
- `req_op`, in, 5: ALU opcode.
- `req_A`, in, 32: operand A.
- `req_B`, in, 32: operand B.
- `req_count`, in, CNT_W: shift amount; used only for OP 01000 and 01001.
- `alu_OP`, out, 5: opcode driven to the ALU.
- `alu_A`, out, 32: operand A driven to the ALU.
- `alu_B`, out, 32: operand B driven to the ALU.
- `alu_result`, in, 32: ALU result.
- `alu_O`, `alu_S`, `alu_C`, `alu_Z`, in, 1 each: ALU flags.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: response consumed.
- `rsp_result`, out, 32: captured result.
- `rsp_O`, `rsp_S`, `rsp_C`, `rsp_Z`, out, 1 each: captured flags.
- `rsp_err`, out, 1: illegal opcode.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation

- FSM states: IDLE, EXEC, ITER, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch op, A, B and count into internal registers. Op, B and count stay fixed until the next accept. A is a working register and is updated on each ITER capture.
  - Next state on accept:
    - Illegal op → RESP, with `rsp_err` = 1, result 0, all flags 0.
    - Shift op with count ≥ 1 → ITER, remaining = count.
    - Any other legal op → EXEC.
- Legal ops: 00000, 00001, 00011, 00100, 00101, 00110, 01000, 01001, 01100, 01101, 01110, and 10000–11111. Every other code is illegal.
- EXEC (one cycle):
  - Drive `alu_OP` = latched op, `alu_A`/`alu_B` = latched operands.
  - At the edge, capture `alu_result` and flags, then go to RESP.
  - Shift op with count 0 executes here as OP 10101 (passa): result = A.
- ITER:
  - Drive `alu_OP` = latched shift op, `alu_A` = working register.
  - Each edge: working register ← `alu_result`, remaining ← remaining − 1.
  - When remaining == 1 at the edge, capture the result and flags and go to RESP.
- Flag sanitising at capture:
  - Arithmetic ops (00xxx): O, S, C, Z pass through from the ALU.
  - Shift ops: S, Z and C from the ALU (C = bit shifted out on the final step); O forced to 0.
  - Shift with count 0: C = 0, O = 0.
  - Logic ops (1xxxx) and load ops (01100–01110): C = 0, O = 0; S and Z from the ALU.
- RESP:
  - `rsp_valid` = 1; response outputs are held stable until `rsp_ready`.
  - On `rsp_ready`, go to IDLE.
- Outside EXEC/ITER:
  - `alu_OP` = 10101, `alu_A` = `alu_B` = 0, so the ALU's internal latches see stable inputs.

## Timing

- Reset values:
  - State = IDLE; `req_ready` = 1 (IDLE).
  - `rsp_valid` = 0, `rsp_err` = 0, `busy` = 0.
  - `rsp_result` = 0; all `rsp_` flags = 0.
  - `alu_OP` = 10101, `alu_A` = `alu_B` = 0.
- Latency, with the accept edge called E0:
  - Single-cycle op: `rsp_valid` high from the cycle after E1.
  - Shift by N ≥ 1: `rsp_valid` high after edge EN.
  - Illegal op: `rsp_valid` high after E0.
- No overlap between requests: `req_ready` = 0 from E0 until the cycle after the response handshake. Minimum request-to-request period for a single-cycle op is 3 cycles.
- `rsp_ready` low holds RESP indefinitely; no data may change while waiting.
- `reset` asserted in any state (including mid-ITER or while held in RESP) returns the block to IDLE at the next edge and discards the operation. `rsp_valid` is low in the following cycle.
- Count is treated as unsigned: maximum 31 iterations, no wrap.

## Test plan

- Add: op 00000, A=5, B=7 → `rsp_result`=12, Z=0, S=0, C=0; `rsp_valid` after E1. Then op 00101, A=3, B=3 → result 0, Z=1.
- Left shift: op 01000, A=0x8000_0001, count 4 → result 0x0000_0010, C=0, O=0, S=0; exactly 4 ITER cycles; `busy` high throughout.
- Arithmetic right shift: op 01001, A=0x8000_0000, count 3 → result 0xF000_0000, S=1, C=0, O=0. Then count 0, A=0x1234 → result 0x1234, C=0, O=0 via a single EXEC.
- Illegal op 00010, A=B=0xFFFF_FFFF → `rsp_err`=1, result 0, all flags 0, `rsp_valid` after E0, ALU opcode never driven to 00010.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after an `and` with A=0xF0F0, B=0xFF00 → result 0xF000 held stable, `req_ready`=0 throughout, C=0, O=0.
- Reset mid-operation: assert `reset` during ITER of a count-20 shift → next cycle IDLE, `rsp_valid`=0, `req_ready`=1. A following add (1+1) returns 2.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle controller in front of a combinational 32-bit ALU.
// Accepts one op at a time, builds multi-bit shifts from 1-bit ALU steps, returns result + sanitised flags.
module alu_sequencer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [31:0]      req_A,
    input  logic [31:0]      req_B,
    input  logic [CNT_W-1:0] req_count,
    output logic [4:0]       alu_OP,
    output logic [31:0]      alu_A,
    output logic [31:0]      alu_B,
    input  logic [31:0]      alu_result,
    input  logic             alu_O,
    input  logic             alu_S,
    input  logic             alu_C,
    input  logic             alu_Z,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_O,
    output logic             rsp_S,
    output logic             rsp_C,
    output logic             rsp_Z,
    output logic             rsp_err,
    output logic             busy
);
    localparam logic [4:0] OP_PASSA = 5'b10101;
    localparam logic [4:0] OP_LSL   = 5'b01000;
    localparam logic [4:0] OP_ASR   = 5'b01001;

    typedef enum logic [1:0] {IDLE, EXEC, ITER, RESP} state_t;

    state_t           state, state_nxt;
    logic [4:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [CNT_W-1:0] rem_q;
    logic             capture;
    logic             flag_o;
    logic             flag_c;

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00001, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b01000, 5'b01001, 5'b01100, 5'b01101, 5'b01110: is_legal = 1'b1;
            default: is_legal = op[4];
        endcase
    endfunction

    function automatic logic is_shift(input logic [4:0] op);
        is_shift = (op == OP_LSL) || (op == OP_ASR);
    endfunction

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!is_legal(req_op))
                        state_nxt = RESP;
                    else if (is_shift(req_op) && req_count != '0)
                        state_nxt = ITER;
                    else
                        state_nxt = EXEC;
                end
            end
            EXEC: begin
                capture   = 1'b1;
                state_nxt = RESP;
            end
            ITER: begin
                if (rem_q == CNT_W'(1)) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A shift with count 0 degenerates to a pass-through of A.
    always_comb begin
        alu_OP = OP_PASSA;
        alu_A  = '0;
        alu_B  = '0;
        if (state == EXEC) begin
            alu_OP = is_shift(op_q) ? OP_PASSA : op_q;
            alu_A  = a_q;
            alu_B  = b_q;
        end else if (state == ITER) begin
            alu_OP = op_q;
            alu_A  = a_q;
            alu_B  = b_q;
        end
    end

    // Only arithmetic ops keep O; only real shift steps and arithmetic keep C.
    always_comb begin
        flag_o = 1'b0;
        flag_c = 1'b0;
        if (op_q[4:3] == 2'b00) begin
            flag_o = alu_O;
            flag_c = alu_C;
        end else if (is_shift(op_q) && state == ITER) begin
            flag_c = alu_C;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            rsp_result <= '0;
            rsp_O      <= 1'b0;
            rsp_S      <= 1'b0;
            rsp_C      <= 1'b0;
            rsp_Z      <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && req_valid) begin
                op_q    <= req_op;
                a_q     <= req_A;
                b_q     <= req_B;
                rem_q   <= req_count;
                rsp_err <= !is_legal(req_op);
                if (!is_legal(req_op)) begin
                    rsp_result <= '0;
                    rsp_O      <= 1'b0;
                    rsp_S      <= 1'b0;
                    rsp_C      <= 1'b0;
                    rsp_Z      <= 1'b0;
                end
            end
            if (state == ITER) begin
                a_q   <= alu_result;
                rem_q <= rem_q - CNT_W'(1);
            end
            if (capture) begin
                rsp_result <= alu_result;
                rsp_O      <= flag_o;
                rsp_S      <= alu_S;
                rsp_C      <= flag_c;
                rsp_Z      <= alu_Z;
            end
        end
    end
endmodule
